// File: rtl/gates_sweep_pkg.sv
// Shared types and constants for the gates self-test sweep controller.
// Expected responses are {y6..y0} = {NOT a, XNOR, XOR, NOR, OR, NAND, AND}.
package gates_sweep_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam int unsigned NUM_VEC = 4;
  localparam int unsigned Y_W     = 7;

  localparam logic [Y_W-1:0] EXP_V0 = 7'h6A;  // a=0 b=0
  localparam logic [Y_W-1:0] EXP_V1 = 7'h16;  // a=1 b=0
  localparam logic [Y_W-1:0] EXP_V2 = 7'h56;  // a=0 b=1
  localparam logic [Y_W-1:0] EXP_V3 = 7'h25;  // a=1 b=1

  function automatic logic [Y_W-1:0] exp_resp(input logic [1:0] idx);
    logic [Y_W-1:0] r;
    unique case (idx)
      2'd0: r = EXP_V0;
      2'd1: r = EXP_V1;
      2'd2: r = EXP_V2;
      2'd3: r = EXP_V3;
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/gates_sweep_check.sv
// Combinational compare of the live gates response against the golden response
// for the vector currently being driven.
module gates_sweep_check
  import gates_sweep_pkg::*;
(
  input  logic [1:0]     idx_i,
  input  logic [Y_W-1:0] gate_y_i,
  output logic           mismatch_o
);

  assign mismatch_o = (gate_y_i != exp_resp(idx_i));

endmodule

// File: rtl/gates_sweep_ctrl.sv
// Self-test sequencer driving the four {b,a} vectors into a gates block and
// capturing each response. Define GATES_SWEEP_CHECK_EN to build the comparator.
module gates_sweep_ctrl
  import gates_sweep_pkg::*;
#(
  parameter int unsigned DWELL = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  output logic                   gate_a,
  output logic                   gate_b,
  input  logic [Y_W-1:0]         gate_y,
  output logic                   busy,
  output logic                   done,
  output logic [NUM_VEC*Y_W-1:0] result,
  output logic                   pass,
  output logic [NUM_VEC-1:0]     err_mask
);

  localparam int unsigned CntW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DWELL - 1);

  state_e                 state_q, state_d;
  logic [1:0]             idx_q, idx_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   gate_a_q, gate_a_d;
  logic                   gate_b_q, gate_b_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [NUM_VEC*Y_W-1:0] result_q, result_d;
  logic                   pass_q, pass_d;
  logic [NUM_VEC-1:0]     err_q, err_d;
  logic                   mismatch;

`ifdef GATES_SWEEP_CHECK_EN
  gates_sweep_check u_check (
    .idx_i      (idx_q),
    .gate_y_i   (gate_y),
    .mismatch_o (mismatch)
  );
`else
  // Without the comparator err_q never leaves zero and pass means "completed".
  assign mismatch = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    gate_a_d = gate_a_q;
    gate_b_d = gate_b_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    pass_d   = pass_q;
    err_d    = err_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d  = StRun;
          idx_d    = '0;
          cnt_d    = '0;
          gate_a_d = 1'b0;
          gate_b_d = 1'b0;
          busy_d   = 1'b1;
          result_d = '0;
          pass_d   = 1'b0;
          err_d    = '0;
        end
      end
      StRun: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          cnt_d = '0;
          result_d[Y_W*idx_q +: Y_W] = gate_y;
          err_d[idx_q] = mismatch;
          if (idx_q == 2'd3) begin
            state_d  = StDone;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            gate_a_d = 1'b0;
            gate_b_d = 1'b0;
            pass_d   = (err_d == '0);
          end else begin
            idx_d    = idx_q + 2'd1;
            gate_a_d = idx_d[0];
            gate_b_d = idx_d[1];
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      cnt_q    <= '0;
      gate_a_q <= 1'b0;
      gate_b_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      pass_q   <= 1'b0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      gate_a_q <= gate_a_d;
      gate_b_q <= gate_b_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      pass_q   <= pass_d;
      err_q    <= err_d;
    end
  end

  assign gate_a   = gate_a_q;
  assign gate_b   = gate_b_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign pass     = pass_q;
  assign err_mask = err_q;

endmodule

// File: tb/tb_gates_sweep_ctrl.sv
// Bench for gates_sweep_ctrl: unit 0 uses DWELL=4, unit 1 uses DWELL=1, each
// feeding a behavioural gates block with injectable stuck-at faults.
module tb_gates_sweep_ctrl;

`ifdef GATES_SWEEP_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start [2];
  logic        ga    [2];
  logic        gb    [2];
  logic [6:0]  gy    [2];
  logic        busy  [2];
  logic        done  [2];
  logic [27:0] res   [2];
  logic        pass  [2];
  logic [3:0]  em    [2];
  logic [6:0]  sa0   [2];
  logic [6:0]  sa1   [2];
  logic [27:0] last_res [2];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  function automatic logic [6:0] gates_fn(input logic a, input logic b);
    return {~a, ~(a ^ b), a ^ b, ~(a | b), a | b, ~(a & b), a & b};
  endfunction

  function automatic logic [6:0] golden(input int k);
    case (k)
      0: return 7'h6A;
      1: return 7'h16;
      2: return 7'h56;
      default: return 7'h25;
    endcase
  endfunction

  function automatic logic [6:0] model_resp(input int k, input logic [6:0] m0,
                                            input logic [6:0] m1);
    logic [1:0] kv;
    kv = 2'(k);
    return (gates_fn(kv[0], kv[1]) & ~m0) | m1;
  endfunction

  assign gy[0] = (gates_fn(ga[0], gb[0]) & ~sa0[0]) | sa1[0];
  assign gy[1] = (gates_fn(ga[1], gb[1]) & ~sa0[1]) | sa1[1];

  gates_sweep_ctrl #(.DWELL(4)) u_dut4 (
    .clk      (clk),
    .reset    (reset),
    .start    (start[0]),
    .gate_a   (ga[0]),
    .gate_b   (gb[0]),
    .gate_y   (gy[0]),
    .busy     (busy[0]),
    .done     (done[0]),
    .result   (res[0]),
    .pass     (pass[0]),
    .err_mask (em[0])
  );

  gates_sweep_ctrl #(.DWELL(1)) u_dut1 (
    .clk      (clk),
    .reset    (reset),
    .start    (start[1]),
    .gate_a   (ga[1]),
    .gate_b   (gb[1]),
    .gate_y   (gy[1]),
    .busy     (busy[1]),
    .done     (done[1]),
    .result   (res[1]),
    .pass     (pass[1]),
    .err_mask (em[1])
  );

  // Pulse start on unit u and check every cycle from the start edge to the first IDLE cycle.
  task automatic run_sweep(input int u, input int d, input logic [6:0] m0,
                           input logic [6:0] m1, input string nm);
    logic [27:0] exp_res;
    logic [3:0]  exp_em, exp_ctrl, got_ctrl;
    logic        exp_pass;
    logic [6:0]  r;
    int          k, ncap;
    sa0[u] = m0;
    sa1[u] = m1;
    start[u] = 1'b1;
    @(posedge clk);
    for (int off = 1; off <= 4 * d + 2; off++) begin
      @(negedge clk);
      start[u] = 1'b0;
      k = (off - 1) / d;
      ncap = (k > 4) ? 4 : k;
      exp_res = '0;
      exp_em = '0;
      for (int j = 0; j < ncap; j++) begin
        r = model_resp(j, m0, m1);
        exp_res[7*j +: 7] = r;
        if (CHK && r != golden(j)) exp_em[j] = 1'b1;
      end
      exp_pass = (off >= 4 * d + 1) && (exp_em == 4'd0);
      exp_ctrl[3] = (off <= 4 * d);
      exp_ctrl[2] = (off == 4 * d + 1);
      exp_ctrl[1] = exp_ctrl[3] && k[0];
      exp_ctrl[0] = exp_ctrl[3] && k[1];
      got_ctrl = {busy[u], done[u], ga[u], gb[u]};
      checks++;
      if (got_ctrl !== exp_ctrl) begin
        failures++;
        $display("FAIL %s ctrl{busy,done,a,b} cycle %0d got=%b exp=%b", nm, off, got_ctrl,
                 exp_ctrl);
      end
      checks++;
      if (res[u] !== exp_res) begin
        failures++;
        $display("FAIL %s result cycle %0d got=%h exp=%h", nm, off, res[u], exp_res);
      end
      checks++;
      if ({pass[u], em[u]} !== {exp_pass, exp_em}) begin
        failures++;
        $display("FAIL %s pass/err_mask cycle %0d got=%b/%b exp=%b/%b", nm, off, pass[u],
                 em[u], exp_pass, exp_em);
      end
      if (off == 4 * d + 2) last_res[u] = exp_res;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start[0] = 1'b1;
    start[1] = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c == 2) begin
        reset = 1'b0;
        start[0] = 1'b0;
        start[1] = 1'b0;
      end
      for (int u = 0; u < 2; u++) begin
        checks++;
        if ({ga[u], gb[u], busy[u], done[u], pass[u], em[u], res[u]} !== 37'd0) begin
          failures++;
          $display("FAIL reset unit%0d cycle %0d got a=%b b=%b busy=%b done=%b pass=%b em=%b res=%h exp all zero",
                   u, c, ga[u], gb[u], busy[u], done[u], pass[u], em[u], res[u]);
        end
      end
    end
    last_res[0] = '0;
    last_res[1] = '0;
  endtask

  task automatic test_golden();
    run_sweep(0, 4, 7'h00, 7'h00, "golden");
    checks++;
    if (res[0] !== 28'h4B58B6A) begin
      failures++;
      $display("FAIL golden_value got=%h exp=%h", res[0], 28'h4B58B6A);
    end
  endtask

  task automatic test_fault_y4();
    run_sweep(0, 4, 7'h10, 7'h00, "fault_y4");
    checks++;
    if ({res[0][13:7], res[0][20:14]} !== {7'h06, 7'h46}) begin
      failures++;
      $display("FAIL fault_slots got=%h/%h exp=06/46", res[0][13:7], res[0][20:14]);
    end
    checks++;
    if ({pass[0], em[0]} !== (CHK ? 5'b0_0110 : 5'b1_0000)) begin
      failures++;
      $display("FAIL fault_flags got pass=%b em=%b exp=%b", pass[0], em[0],
               (CHK ? 5'b0_0110 : 5'b1_0000));
    end
    sa0[0] = '0;
  endtask

  task automatic test_dwell1();
    run_sweep(1, 1, 7'h00, 7'h00, "dwell1");
    checks++;
    if (res[1] !== 28'h4B58B6A) begin
      failures++;
      $display("FAIL dwell1_value got=%h exp=%h", res[1], 28'h4B58B6A);
    end
  endtask

  task automatic test_start_hold();
    int dcyc[$];
    int budget;
    sa0[0] = '0;
    sa1[0] = '0;
    start[0] = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (done[0] === 1'b1) dcyc.push_back(c);
    end
    start[0] = 1'b0;
    checks++;
    if (dcyc.size() != 2) begin
      failures++;
      $display("FAIL start_hold done_count got=%0d exp=2", dcyc.size());
    end else begin
      checks++;
      if (dcyc[0] != 17 || dcyc[1] - dcyc[0] != 18) begin
        failures++;
        $display("FAIL start_hold done_cycles got=%0d,%0d exp=17,35", dcyc[0], dcyc[1]);
      end
    end
    // A third sweep was accepted before start dropped; let it drain.
    budget = 0;
    while (done[0] !== 1'b1 && budget < 40) begin
      @(negedge clk);
      budget++;
    end
    checks++;
    if (done[0] !== 1'b1) begin
      failures++;
      $display("FAIL start_hold drain_timeout got done=%b exp=1", done[0]);
    end
    @(negedge clk);
    last_res[0] = res[0];
  endtask

  task automatic test_reset_mid();
    sa0[0] = '0;
    sa1[0] = '0;
    start[0] = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      start[0] = 1'b0;
    end
    checks++;
    if ({busy[0], res[0][6:0]} !== {1'b1, 7'h6A}) begin
      failures++;
      $display("FAIL reset_mid pre got busy=%b slot0=%h exp busy=1 slot0=6a", busy[0],
               res[0][6:0]);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({ga[0], gb[0], busy[0], done[0], pass[0], em[0], res[0]} !== 37'd0) begin
      failures++;
      $display("FAIL reset_mid post got a=%b b=%b busy=%b done=%b pass=%b em=%b res=%h exp all zero",
               ga[0], gb[0], busy[0], done[0], pass[0], em[0], res[0]);
    end
    last_res[0] = '0;
    last_res[1] = '0;
    run_sweep(0, 4, 7'h00, 7'h00, "after_reset");
  endtask

  task automatic test_random();
    int         u, gap;
    logic [6:0] m0, m1;
    for (int it = 0; it < 8; it++) begin
      u = $urandom_range(0, 1);
      m0 = ($urandom_range(0, 1) == 0) ? 7'd0 : 7'($urandom);
      m1 = ($urandom_range(0, 2) == 0) ? (7'($urandom) & ~m0) : 7'd0;
      gap = $urandom_range(0, 4);
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        checks++;
        if ({busy[u], done[u], res[u]} !== {2'b00, last_res[u]}) begin
          failures++;
          $display("FAIL random_idle unit%0d got busy=%b done=%b res=%h exp 0/0/%h", u,
                   busy[u], done[u], res[u], last_res[u]);
        end
      end
      run_sweep(u, (u == 0) ? 4 : 1, m0, m1, "random");
    end
  endtask

  initial begin
    sa0[0] = '0;
    sa0[1] = '0;
    sa1[0] = '0;
    sa1[1] = '0;
    reset = 1'b1;
    start[0] = 1'b0;
    start[1] = 1'b0;
    test_reset();
    test_golden();
    test_fault_y4();
    test_dwell1();
    test_start_hold();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
